// File: rtl/cam_axis_pkg.sv
// Shared types and helpers for the camera-to-AXI4-Stream bridge.
package cam_axis_pkg;

    // Frame capture states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2,
        DROP       = 2'd3
    } state_e;

    // FIFO entry carries {sof, eol, data}
    function automatic int entry_w(input int data_w);
        return data_w + 2;
    endfunction

    // Increment that sticks at max_v; callers cast the result down to their width
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through output stage.
// level counts every stored entry, including the one sitting in the output register.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1024,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             wr, pop, load, mem_nonempty;

    // Pointer/occupancy bookkeeping and output-stage refill
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        wr           = wr_en & ~full;
        pop          = out_vld_q & rd_en;
        // entries in memory = level minus the one held in the output register
        mem_nonempty = (level_q != {{(LW-1){1'b0}}, out_vld_q});
        load         = mem_nonempty & (~out_vld_q | pop);
        wr_ptr_d     = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d      = level_q + LW'(wr) - LW'(pop);
        out_vld_d    = load | (out_vld_q & ~pop);
        out_data_d   = load ? mem[rd_ptr_q] : out_data_q;
    end

    // Control and output-stage registers
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_vld_q;
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/cam_axis_bridge.sv
// OV7670 pixel stream to AXI4-Stream video master. A one-pixel hold register
// delays each pixel until we know whether it ends its line (tlast). Frames that
// overflow the FIFO are truncated and the remainder dropped until the next vsync.
module cam_axis_bridge
    import cam_axis_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 1024,
    parameter int LINE_W     = 640,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          vsync,
    input  logic                          href,
    input  logic                          pix_valid,
    input  logic [DATA_W-1:0]             pix_data,
    output logic [DATA_W-1:0]             m_axis_video_tdata,
    output logic                          m_axis_video_tvalid,
    input  logic                          m_axis_video_tready,
    output logic                          m_axis_video_tuser,
    output logic                          m_axis_video_tlast,
    input  logic                          clear_err,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              line_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int          EW      = entry_w(DATA_W);
    localparam int          LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int          LC_W    = $clog2(LINE_W) + 2;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);
    localparam logic [31:0] LC_MAX  = 32'hFFFF_FFFF >> (32 - LC_W);

    state_e              state_q, state_d;
    logic                vsync_q, href_q;
    logic                sof_pend_q, sof_pend_d;
    logic                hold_vld_q, hold_vld_d;
    logic                hold_sof_q, hold_sof_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic [LC_W-1:0]     line_cnt_q, line_cnt_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    line_err_q, line_err_d;

    logic                vs_rise, vs_fall, href_rise, href_fall, accept;
    logic                push, push_eol, ovf;
    logic [EW-1:0]       fifo_dout;
    logic                fifo_vld, fifo_full, unused_fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign href_rise = href & ~href_q;
    assign href_fall = ~href & href_q;
    assign accept    = (state_q == ACTIVE) & pix_valid & href;

    // State register
    always_ff @(posedge clk) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; a vsync rise closes the frame even if it also overflowed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (vs_rise && enable) state_d = WAIT_FRAME;
            WAIT_FRAME: if (vs_fall) state_d = ACTIVE;
            ACTIVE, DROP: begin
                if (vs_rise)  state_d = enable ? WAIT_FRAME : IDLE;
                else if (ovf) state_d = DROP;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Hold register and FIFO push; at most one push per cycle
    always_comb begin
        push        = 1'b0;
        push_eol    = 1'b0;
        hold_vld_d  = hold_vld_q;
        hold_sof_d  = hold_sof_q;
        hold_data_d = hold_data_q;
        sof_pend_d  = sof_pend_q;
        if (state_q == WAIT_FRAME && vs_fall) sof_pend_d = 1'b1;
        if (state_q == ACTIVE) begin
            if (vs_rise) begin
                // frame ended with href still high: close the line here
                push       = hold_vld_q;
                push_eol   = 1'b1;
                hold_vld_d = 1'b0;
            end else if (accept) begin
                push        = hold_vld_q;
                hold_vld_d  = 1'b1;
                hold_data_d = pix_data;
                hold_sof_d  = sof_pend_q;
                sof_pend_d  = 1'b0;
            end else if (href_fall && hold_vld_q) begin
                push       = 1'b1;
                push_eol   = 1'b1;
                hold_vld_d = 1'b0;
            end
        end
        ovf = push & fifo_full;
        if (ovf) hold_vld_d = 1'b0;
    end

    // Line length and error counters; clear_err beats any same-cycle increment
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (state_q == WAIT_FRAME && vs_fall) line_cnt_d = '0;
        else if (href_rise)                   line_cnt_d = accept ? LC_W'(1) : '0;
        else if (accept)                      line_cnt_d = LC_W'(sat_inc(32'(line_cnt_q), LC_MAX));

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        line_err_d = line_err_q;
        if (clear_err) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            line_err_d = '0;
        end else begin
            if (ovf) begin
                overflow_d = 1'b1;
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_MAX));
            end
            if (state_q == ACTIVE && href_fall && line_cnt_q != LC_W'(LINE_W))
                line_err_d = CNT_W'(sat_inc(32'(line_err_q), CNT_MAX));
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            sof_pend_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_sof_q  <= 1'b0;
            hold_data_q <= '0;
            line_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            line_err_q  <= '0;
        end else begin
            vsync_q     <= vsync;
            href_q      <= href;
            sof_pend_q  <= sof_pend_d;
            hold_vld_q  <= hold_vld_d;
            hold_sof_q  <= hold_sof_d;
            hold_data_q <= hold_data_d;
            line_cnt_q  <= line_cnt_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            line_err_q  <= line_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .LW    (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .aresetn  (aresetn),
        .wr_en    (push),
        .wr_data  ({hold_sof_q, push_eol, hold_data_q}),
        .rd_en    (m_axis_video_tready),
        .rd_data  (fifo_dout),
        .rd_valid (fifo_vld),
        .full     (fifo_full),
        .empty    (unused_fifo_empty),
        .level    (fifo_level)
    );

    assign m_axis_video_tdata  = fifo_dout[DATA_W-1:0];
    assign m_axis_video_tlast  = fifo_dout[DATA_W];
    assign m_axis_video_tuser  = fifo_dout[DATA_W+1];
    assign m_axis_video_tvalid = fifo_vld;
    assign overflow            = overflow_q;
    assign drop_cnt            = drop_cnt_q;
    assign line_err_cnt        = line_err_q;
    assign level               = fifo_level;

endmodule

// File: tb/tb_cam_axis_bridge.sv
// Randomized bench for cam_axis_bridge with a queue-based reference model.
module tb_cam_axis_bridge;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 4;
    localparam int CW    = 4;
    localparam int LVW   = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int LCMAX = (1 << ($clog2(LW) + 2)) - 1;

    logic clk = 1'b0;
    logic aresetn, enable, vsync, href, pix_valid, tready, clear_err;
    logic [DW-1:0]  pix_data, tdata;
    logic           tvalid, tuser, tlast, overflow;
    logic [CW-1:0]  drop_cnt, line_err_cnt;
    logic [LVW-1:0] level;

    always #5 clk = ~clk;

    cam_axis_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LINE_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable), .vsync(vsync), .href(href),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
        .m_axis_video_tlast(tlast), .clear_err(clear_err), .overflow(overflow),
        .drop_cnt(drop_cnt), .line_err_cnt(line_err_cnt), .level(level)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        bit            sof;
        bit            eol;
        int            t;
    } ent_t;

    ent_t q[$];
    bit   m_vs, m_hr, armed, in_frame, dropping, sof_next, have, hs, m_ovf, exp_vld;
    logic [DW-1:0] hd;
    int   llen, m_lerr, m_drops, edge_n;
    logic [DW+1:0] beats[$];
    int   rmode;
    bit   gaps;

    // Advance the model by one clock edge using the inputs presented before it
    task automatic model_step();
        bit vr, vf, hr_r, hf, cap, acc, do_push, lbad, pop, ovf_ev;
        ent_t e;
        edge_n++;
        if (!aresetn) begin
            q.delete();
            armed = 0; in_frame = 0; dropping = 0; sof_next = 0; have = 0;
            llen = 0; m_lerr = 0; m_drops = 0; m_ovf = 0; exp_vld = 0;
            m_vs = 0; m_hr = 0;
            return;
        end
        vr   = vsync && !m_vs;
        vf   = !vsync && m_vs;
        hr_r = href && !m_hr;
        hf   = !href && m_hr;
        cap  = in_frame && !dropping;
        acc  = cap && pix_valid && href;
        do_push = 0;
        e = '{hd, hs, 1'b0, edge_n};
        if (cap) begin
            if (vr) begin
                if (have) begin do_push = 1; e.eol = 1; end
                have = 0;
            end else if (acc) begin
                if (have) do_push = 1;
                hd = pix_data; hs = sof_next; sof_next = 0; have = 1;
            end else if (hf && have) begin
                do_push = 1; e.eol = 1; have = 0;
            end
        end
        lbad = cap && hf && (llen != LW);
        if (armed && vf)       llen = 0;
        else if (hr_r)         llen = acc ? 1 : 0;
        else if (acc && llen < LCMAX) llen++;
        pop    = exp_vld && tready;
        ovf_ev = do_push && (q.size() == DEPTH);
        if (ovf_ev) have = 0;
        if (in_frame && vr) begin
            in_frame = 0; dropping = 0; armed = enable;
        end else if (!in_frame && !armed && vr && enable) begin
            armed = 1;
        end else if (armed && vf) begin
            armed = 0; in_frame = 1; sof_next = 1;
        end else if (ovf_ev) begin
            dropping = 1;
        end
        if (clear_err) begin
            m_ovf = 0; m_drops = 0; m_lerr = 0;
        end else begin
            if (ovf_ev) begin
                m_ovf = 1;
                if (m_drops < CMAX) m_drops++;
            end
            if (lbad && m_lerr < CMAX) m_lerr++;
        end
        if (do_push && !ovf_ev) q.push_back(e);
        if (pop) void'(q.pop_front());
        exp_vld = (q.size() > 0) && (q[0].t < edge_n);
        m_vs = vsync;
        m_hr = href;
    endtask

    // One clock: log any handshake, step model, compare all outputs
    task automatic cycle();
        if (tvalid && tready) beats.push_back({tuser, tlast, tdata});
        @(posedge clk);
        model_step();
        #1;
        chk("tvalid", tvalid, exp_vld);
        if (exp_vld) begin
            chk("tdata", tdata, q[0].d);
            chk("tuser", tuser, q[0].sof);
            chk("tlast", tlast, q[0].eol);
        end
        chk("level", level, q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("line_err_cnt", line_err_cnt, m_lerr);
    endtask

    task automatic step();
        case (rmode)
            0: tready = 1'b1;
            1: tready = ~tready;
            2: tready = 1'($urandom % 2);
            default: tready = 1'b0;
        endcase
        cycle();
    endtask

    task automatic drain(input int n);
        rmode = 0; href = 0; pix_valid = 0;
        repeat (n) step();
    endtask

    task automatic line(input int len);
        int k;
        k = 0;
        href = 1;
        while (k < len) begin
            pix_valid = gaps ? ($urandom % 4 != 0) : 1'b1;
            if (pix_valid) begin pix_data = DW'($urandom); k++; end
            step();
        end
        href = 0; pix_valid = 0;
        repeat (3) step();
    endtask

    // Frame of n lines; even lines length a, odd lines b; 0 means random 2..6
    task automatic frame(input int n, input int a, input int b);
        int len;
        vsync = 1; href = 0; pix_valid = 0;
        repeat (3) step();
        vsync = 0;
        repeat (2) step();
        for (int i = 0; i < n; i++) begin
            len = (i % 2 == 0) ? a : b;
            if (len == 0) len = $urandom_range(2, 6);
            line(len);
        end
        repeat (2) step();
    endtask

    initial begin
        aresetn = 0; enable = 1; vsync = 0; href = 0; pix_valid = 0;
        pix_data = '0; tready = 1; clear_err = 0; rmode = 0; gaps = 0;
        edge_n = 0;
        repeat (2) step();
        chk("reset_tvalid", tvalid, 0);
        chk("reset_level", level, 0);
        aresetn = 1;

        // 2x4 frame, tready high
        beats.delete();
        frame(2, 4, 4);
        drain(6);
        chk("t1_beats", beats.size(), 8);
        chk("t1_sof0", beats[0][DW+1], 1);
        chk("t1_sof1", beats[1][DW+1], 0);
        chk("t1_eol3", beats[3][DW], 1);
        chk("t1_eol2", beats[2][DW], 0);
        chk("t1_eol7", beats[7][DW], 1);
        chk("t1_lerr", line_err_cnt, 0);

        // same frame, tready toggling
        beats.delete();
        rmode = 1;
        frame(2, 4, 4);
        drain(10);
        chk("t2_beats", beats.size(), 8);
        chk("t2_eol7", beats[7][DW], 1);

        // overflow with stalled sink
        rmode = 3;
        frame(1, 6, 6);
        chk("t3_level", level, 4);
        chk("t3_overflow", overflow, 1);
        chk("t3_drop", drop_cnt, 1);
        drain(8);
        beats.delete();
        frame(1, 4, 4);
        drain(8);
        chk("t3_next_beats", beats.size(), 4);
        chk("t3_next_sof", beats[0][DW+1], 1);
        chk("t3_next_eol", beats[3][DW], 1);

        // malformed line lengths
        frame(2, 3, 5);
        drain(8);
        chk("t4_lerr", line_err_cnt, 2);
        clear_err = 1;
        step();
        clear_err = 0;
        chk("t4_lerr_clr", line_err_cnt, 0);
        chk("t4_drop_clr", drop_cnt, 0);
        chk("t4_ovf_clr", overflow, 0);

        // reset mid-line with two entries queued
        rmode = 3;
        vsync = 1; repeat (3) step();
        vsync = 0; repeat (2) step();
        href = 1; pix_valid = 1;
        repeat (3) begin pix_data = DW'($urandom); step(); end
        pix_valid = 0;
        chk("t5_level_pre", level, 2);
        aresetn = 0; step(); aresetn = 1;
        chk("t5_tvalid", tvalid, 0);
        chk("t5_level", level, 0);
        beats.delete();
        line(4);
        drain(6);
        chk("t5_no_vsync_beats", beats.size(), 0);
        frame(1, 4, 4);
        drain(8);
        chk("t5_after_beats", beats.size(), 4);

        // enable handling
        aresetn = 0; step(); aresetn = 1;
        enable = 0;
        beats.delete();
        frame(1, 4, 4);
        drain(8);
        chk("t6_disabled_beats", beats.size(), 0);
        enable = 1;
        beats.delete();
        frame(1, 4, 4);
        enable = 0;
        frame(1, 4, 4);
        drain(10);
        chk("t6_finish_frame_beats", beats.size(), 4);

        // randomized frames
        enable = 1;
        for (int f = 0; f < 40; f++) begin
            rmode = $urandom % 4;
            gaps  = 1'($urandom % 2);
            if ($urandom % 8 == 0) enable = ~enable;
            frame($urandom_range(1, 3), 0, 0);
            if ($urandom % 6 == 0) begin clear_err = 1; step(); clear_err = 0; end
            if ($urandom % 3 == 0) drain(6);
        end
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
